// File: rtl/dcpu16_arb.sv
// dcpu16_arb: two-master (f, g) to one-slave memory bus arbiter.
// Masters are served round-robin, one transaction at a time. The slave ack and
// read data go straight back to the owner. A watchdog ends transactions the
// slave never acknowledges and raises a sticky tmo flag.
//
// Handshake: a master raises x_stb with adr/wre/dto stable and holds it until
// it sees x_ack=1. That ack cycle is the single cycle in which the transfer
// completes and x_dti is valid. Dropping x_stb before the ack aborts the
// request. A stb still high in the cycle after the ack is a new request.
// The slave side follows the same rules on m_stb/m_ack.
module dcpu16_arb #(
    parameter int unsigned TMO = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] f_adr,
    input  logic        f_stb,
    input  logic        f_wre,
    input  logic [15:0] f_dto,
    output logic [15:0] f_dti,
    output logic        f_ack,
    input  logic [15:0] g_adr,
    input  logic        g_stb,
    input  logic        g_wre,
    input  logic [15:0] g_dto,
    output logic [15:0] g_dti,
    output logic        g_ack,
    output logic [15:0] m_adr,
    output logic        m_stb,
    output logic        m_wre,
    output logic [15:0] m_dto,
    input  logic [15:0] m_dti,
    input  logic        m_ack,
    output logic [1:0]  gnt,
    output logic        tmo,
    input  logic        tmo_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSF = 2'd1,
        BUSG = 2'd2
    } state_t;

    localparam logic [7:0] TMO_CNT = 8'(TMO);

    state_t     state;
    logic       last;      // last-served master: 0 = f, 1 = g
    logic [7:0] cnt;       // cycles of the current ownership without an ack
    logic       own_stb;
    logic       wd;        // watchdog fires this cycle

    // gnt is a direct view of the FSM state, so it doubles as the state probe.
    assign gnt = {state == BUSG, state == BUSF};

    // Owner's strobe and the watchdog condition. A real ack in the limit
    // cycle wins, and a dropped strobe is an abort rather than a timeout.
    always_comb begin
        own_stb = 1'b0;
        if (state == BUSF) begin
            own_stb = f_stb;
        end else if (state == BUSG) begin
            own_stb = g_stb;
        end
        wd = (state != IDLE) && own_stb && (cnt == TMO_CNT) && !m_ack;
    end

    // Arbitration FSM, round-robin pointer, watchdog counter and sticky flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= 8'd0;
            tmo   <= 1'b0;
        end else begin
            if (wd) begin
                tmo <= 1'b1;
            end else if (tmo_clr) begin
                tmo <= 1'b0;
            end
            case (state)
                IDLE: begin
                    cnt <= 8'd0;
                    if (f_stb && (!g_stb || last)) begin
                        state <= BUSF;
                    end else if (g_stb) begin
                        state <= BUSG;
                    end
                end
                BUSF: begin
                    if (m_ack || wd) begin
                        last  <= 1'b0;
                        cnt   <= 8'd0;
                        state <= g_stb ? BUSG : IDLE;
                    end else if (!f_stb) begin
                        cnt   <= 8'd0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                BUSG: begin
                    if (m_ack || wd) begin
                        last  <= 1'b1;
                        cnt   <= 8'd0;
                        state <= f_stb ? BUSF : IDLE;
                    end else if (!g_stb) begin
                        cnt   <= 8'd0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    cnt   <= 8'd0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Bus mux: the owner drives the slave and receives the ack; the watchdog
    // supplies a fake ack with zero data and withdraws the slave strobe.
    always_comb begin
        m_adr = 16'h0000;
        m_stb = 1'b0;
        m_wre = 1'b0;
        m_dto = 16'h0000;
        f_ack = 1'b0;
        g_ack = 1'b0;
        f_dti = m_dti;
        g_dti = m_dti;
        case (state)
            BUSF: begin
                m_adr = f_adr;
                m_wre = f_wre;
                m_dto = f_dto;
                m_stb = f_stb && !wd;
                f_ack = m_ack || wd;
                if (wd) begin
                    f_dti = 16'h0000;
                end
            end
            BUSG: begin
                m_adr = g_adr;
                m_wre = g_wre;
                m_dto = g_dto;
                m_stb = g_stb && !wd;
                g_ack = m_ack || wd;
                if (wd) begin
                    g_dti = 16'h0000;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dcpu16_arb.sv
// Testbench for dcpu16_arb with a 4-cycle watchdog limit. Inputs change 1 ns
// after each rising edge and outputs are checked on the falling edge. Every
// ack is checked against a queue of expected {owner, read data} entries
// pushed when the slave response is driven.
module tb_dcpu16_arb;

    logic        clk;
    logic        rst;
    logic [15:0] f_adr, f_dto, f_dti;
    logic        f_stb, f_wre, f_ack;
    logic [15:0] g_adr, g_dto, g_dti;
    logic        g_stb, g_wre, g_ack;
    logic [15:0] m_adr, m_dto, m_dti;
    logic        m_stb, m_wre, m_ack;
    logic [1:0]  gnt;
    logic        tmo, tmo_clr;

    int n_checks = 0;
    int n_fail   = 0;

    // {gnt of owner, read data the owner must see with its ack}
    logic [17:0] exp_q[$];
    logic [17:0] sb_exp, sb_got;

    dcpu16_arb #(.TMO(4)) dut (
        .clk(clk), .rst(rst),
        .f_adr(f_adr), .f_stb(f_stb), .f_wre(f_wre), .f_dto(f_dto), .f_dti(f_dti), .f_ack(f_ack),
        .g_adr(g_adr), .g_stb(g_stb), .g_wre(g_wre), .g_dto(g_dto), .g_dti(g_dti), .g_ack(g_ack),
        .m_adr(m_adr), .m_stb(m_stb), .m_wre(m_wre), .m_dto(m_dto), .m_dti(m_dti), .m_ack(m_ack),
        .gnt(gnt), .tmo(tmo), .tmo_clr(tmo_clr)
    );

    // Clock and run-time bound
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout: simulation did not finish within 100000 ns");
        $fatal(1, "timeout");
    end

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    // Scoreboard: every ack seen must match the oldest expected entry
    always @(negedge clk) begin
        if (f_ack || g_ack) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_ack: got f_ack=%0b g_ack=%0b, required no ack", f_ack, g_ack);
            end else begin
                sb_exp = exp_q.pop_front();
                sb_got = {g_ack, f_ack, (f_ack ? f_dti : g_dti)};
                if (sb_got !== sb_exp) begin
                    n_fail++;
                    $display("FAIL sb_ack_data: got {g_ack,f_ack,dti}=%h, required %h", sb_got, sb_exp);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        to_drive();
        to_drive();
        to_sample();
        n_checks++;
        if ({gnt, tmo, f_ack, g_ack, m_stb, m_wre, m_adr, m_dto} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gnt=%b tmo=%b f_ack=%b g_ack=%b m_stb=%b m_wre=%b m_adr=%h m_dto=%h, required all 0",
                     gnt, tmo, f_ack, g_ack, m_stb, m_wre, m_adr, m_dto);
        end
        to_drive();
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        to_drive();
        f_stb = 1'b1; f_adr = 16'h1234; f_wre = 1'b0; f_dto = 16'h0000;
        to_sample();
        n_checks++;
        if (gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL rd_idle_gnt: got %b, required 00", gnt);
        end
        to_drive();
        to_sample();
        n_checks++;
        if ({gnt, m_stb, m_wre, m_adr, f_ack, g_ack} !== {2'b01, 1'b1, 1'b0, 16'h1234, 2'b00}) begin
            n_fail++;
            $display("FAIL rd_grant: got gnt=%b m_stb=%b m_wre=%b m_adr=%h f_ack=%b g_ack=%b, required 01 1 0 1234 0 0",
                     gnt, m_stb, m_wre, m_adr, f_ack, g_ack);
        end
        to_drive();
        m_ack = 1'b1; m_dti = 16'hBEEF;
        exp_q.push_back({2'b01, 16'hBEEF});
        to_sample();
        n_checks++;
        if ({f_ack, f_dti, g_ack} !== {1'b1, 16'hBEEF, 1'b0}) begin
            n_fail++;
            $display("FAIL rd_ack: got f_ack=%b f_dti=%h g_ack=%b, required 1 beef 0", f_ack, f_dti, g_ack);
        end
        to_drive();
        f_stb = 1'b0; m_ack = 1'b0;
        to_sample();
        n_checks++;
        if ({gnt, f_ack, m_stb} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rd_done: got gnt=%b f_ack=%b m_stb=%b, required 00 0 0", gnt, f_ack, m_stb);
        end
    endtask

    task automatic test_simultaneous();
        logic [15:0] d;
        to_drive();
        rst = 1'b1;
        to_drive();
        rst = 1'b0;
        for (int r = 0; r < 2; r++) begin
            to_drive();
            f_stb = 1'b1; f_adr = 16'h1000 + 16'(r);
            g_stb = 1'b1; g_adr = 16'h2000 + 16'(r);
            to_sample();
            n_checks++;
            if (gnt !== 2'b00) begin
                n_fail++;
                $display("FAIL sim_idle_gnt[%0d]: got %b, required 00", r, gnt);
            end
            to_drive();
            to_sample();
            n_checks++;
            if ({gnt, m_adr} !== {2'b01, 16'h1000 + 16'(r)}) begin
                n_fail++;
                $display("FAIL sim_first_f[%0d]: got gnt=%b m_adr=%h, required 01 %h", r, gnt, m_adr, 16'h1000 + 16'(r));
            end
            to_drive();
            d = 16'($urandom_range(0, 65535));
            m_ack = 1'b1; m_dti = d;
            exp_q.push_back({2'b01, d});
            to_sample();
            to_drive();
            f_stb = 1'b0; m_ack = 1'b0;
            to_sample();
            n_checks++;
            if ({gnt, m_stb, m_adr} !== {2'b10, 1'b1, 16'h2000 + 16'(r)}) begin
                n_fail++;
                $display("FAIL sim_handoff_g[%0d]: got gnt=%b m_stb=%b m_adr=%h, required 10 1 %h",
                         r, gnt, m_stb, m_adr, 16'h2000 + 16'(r));
            end
            to_drive();
            d = 16'($urandom_range(0, 65535));
            m_ack = 1'b1; m_dti = d;
            exp_q.push_back({2'b10, d});
            to_sample();
            to_drive();
            g_stb = 1'b0; m_ack = 1'b0;
            to_sample();
            n_checks++;
            if (gnt !== 2'b00) begin
                n_fail++;
                $display("FAIL sim_back_idle[%0d]: got %b, required 00", r, gnt);
            end
        end
    endtask

    task automatic test_fairness();
        logic [1:0]  own;
        logic [15:0] d;
        to_drive();
        f_stb = 1'b1; f_adr = 16'h0F0F;
        g_stb = 1'b1; g_adr = 16'h0E0E;
        m_ack = 1'b0;
        to_sample();
        own = 2'b01;
        for (int i = 0; i < 6; i++) begin
            to_drive();
            d = 16'($urandom_range(0, 65535));
            m_ack = 1'b1; m_dti = d;
            exp_q.push_back({own, d});
            if (i == 5) f_stb = 1'b0;
            to_sample();
            n_checks++;
            if (gnt !== own) begin
                n_fail++;
                $display("FAIL fair_grant[%0d]: got %b, required %b", i, gnt, own);
            end
            own = {own[0], own[1]};
        end
        to_drive();
        g_stb = 1'b0; m_ack = 1'b0;
        to_sample();
        n_checks++;
        if (gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL fair_idle: got %b, required 00", gnt);
        end
    endtask

    task automatic test_watchdog();
        to_drive();
        g_stb = 1'b1; g_wre = 1'b1; g_adr = 16'hA5A5; g_dto = 16'h5A5A; m_dti = 16'hFFFF;
        to_sample();
        for (int k = 1; k <= 5; k++) begin
            to_drive();
            if (k == 5) exp_q.push_back({2'b10, 16'h0000});
            to_sample();
            n_checks++;
            if (k < 5) begin
                if ({gnt, m_stb, m_wre, m_dto, g_ack} !== {2'b10, 1'b1, 1'b1, 16'h5A5A, 1'b0}) begin
                    n_fail++;
                    $display("FAIL wd_wait[%0d]: got gnt=%b m_stb=%b m_wre=%b m_dto=%h g_ack=%b, required 10 1 1 5a5a 0",
                             k, gnt, m_stb, m_wre, m_dto, g_ack);
                end
            end else begin
                if ({gnt, m_stb, g_ack, g_dti, f_dti, tmo} !== {2'b10, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 1'b0}) begin
                    n_fail++;
                    $display("FAIL wd_fire: got gnt=%b m_stb=%b g_ack=%b g_dti=%h f_dti=%h tmo=%b, required 10 0 1 0000 ffff 0",
                             gnt, m_stb, g_ack, g_dti, f_dti, tmo);
                end
            end
        end
        to_drive();
        g_stb = 1'b0; g_wre = 1'b0;
        to_sample();
        n_checks++;
        if ({tmo, gnt} !== 3'b100) begin
            n_fail++;
            $display("FAIL wd_flag_set: got tmo=%b gnt=%b, required 1 00", tmo, gnt);
        end
        to_drive();
        tmo_clr = 1'b1;
        to_drive();
        tmo_clr = 1'b0;
        to_sample();
        n_checks++;
        if (tmo !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_flag_clr: got tmo=%b, required 0", tmo);
        end
        // A real ack in the limit cycle is a normal completion
        to_drive();
        g_stb = 1'b1;
        to_sample();
        for (int k = 1; k <= 5; k++) begin
            to_drive();
            if (k == 5) begin
                m_ack = 1'b1; m_dti = 16'h7777;
                exp_q.push_back({2'b10, 16'h7777});
            end
            to_sample();
        end
        n_checks++;
        if ({m_stb, g_ack, g_dti} !== {1'b1, 1'b1, 16'h7777}) begin
            n_fail++;
            $display("FAIL wd_real_ack: got m_stb=%b g_ack=%b g_dti=%h, required 1 1 7777", m_stb, g_ack, g_dti);
        end
        to_drive();
        g_stb = 1'b0; m_ack = 1'b0;
        to_sample();
        n_checks++;
        if ({tmo, gnt} !== 3'b000) begin
            n_fail++;
            $display("FAIL wd_real_noflag: got tmo=%b gnt=%b, required 0 00", tmo, gnt);
        end
    endtask

    task automatic test_abort();
        to_drive();
        f_stb = 1'b1; f_adr = 16'h0ABC;
        to_sample();
        to_drive();
        to_sample();
        n_checks++;
        if (gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL ab_grant: got %b, required 01", gnt);
        end
        to_drive();
        f_stb = 1'b0;
        to_sample();
        n_checks++;
        if ({f_ack, m_stb} !== 2'b00) begin
            n_fail++;
            $display("FAIL ab_no_ack: got f_ack=%b m_stb=%b, required 0 0", f_ack, m_stb);
        end
        to_drive();
        to_sample();
        n_checks++;
        if (gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL ab_idle: got %b, required 00", gnt);
        end
        // The abort leaves last = g, so f still wins a tie
        to_drive();
        f_stb = 1'b1; g_stb = 1'b1;
        to_sample();
        to_drive();
        to_sample();
        n_checks++;
        if (gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL ab_last_kept: got %b, required 01", gnt);
        end
        to_drive();
        f_stb = 1'b0; g_stb = 1'b0;
        to_drive();
        to_sample();
        n_checks++;
        if (gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL ab_idle2: got %b, required 00", gnt);
        end
    endtask

    task automatic test_reset_mid();
        to_drive();
        g_stb = 1'b1; g_wre = 1'b1; g_adr = 16'hC0DE; g_dto = 16'h1357;
        to_sample();
        to_drive();
        to_sample();
        n_checks++;
        if ({gnt, m_adr} !== {2'b10, 16'hC0DE}) begin
            n_fail++;
            $display("FAIL rm_grant: got gnt=%b m_adr=%h, required 10 c0de", gnt, m_adr);
        end
        to_drive();
        rst = 1'b1;
        to_drive();
        rst = 1'b0; g_stb = 1'b0; g_wre = 1'b0;
        to_sample();
        n_checks++;
        if ({gnt, tmo, f_ack, g_ack, m_stb, m_wre, m_adr, m_dto} !== 39'd0) begin
            n_fail++;
            $display("FAIL rm_outputs: got gnt=%b tmo=%b f_ack=%b g_ack=%b m_stb=%b m_wre=%b m_adr=%h m_dto=%h, required all 0",
                     gnt, tmo, f_ack, g_ack, m_stb, m_wre, m_adr, m_dto);
        end
        to_drive();
        g_stb = 1'b1;
        to_sample();
        to_drive();
        to_sample();
        n_checks++;
        if ({gnt, m_stb} !== 3'b101) begin
            n_fail++;
            $display("FAIL rm_regrant: got gnt=%b m_stb=%b, required 10 1", gnt, m_stb);
        end
        to_drive();
        m_ack = 1'b1; m_dti = 16'h2468;
        exp_q.push_back({2'b10, 16'h2468});
        to_sample();
        to_drive();
        g_stb = 1'b0; m_ack = 1'b0;
        to_sample();
        n_checks++;
        if (gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL rm_idle: got %b, required 00", gnt);
        end
    endtask

    initial begin
        rst = 1'b1; tmo_clr = 1'b0;
        f_adr = '0; f_stb = 1'b0; f_wre = 1'b0; f_dto = '0;
        g_adr = '0; g_stb = 1'b0; g_wre = 1'b0; g_dto = '0;
        m_dti = '0; m_ack = 1'b0;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_fairness();
        test_watchdog();
        test_abort();
        test_reset_mid();
        to_drive();
        to_sample();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending expected acks, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcpu16_arb.md
# dcpu16_arb

Two-master, one-slave memory bus arbiter for the DCPU16 core. It shares a single memory port between the CPU fetch/data bus (f) and the operand bus (g). Requesters are granted round-robin, one transaction at a time. Slave acknowledges and read data pass straight back to the owner, and a watchdog terminates transactions the slave never acknowledges. It sits between the CPU top level and the external memory or peripheral fabric.

## Interface
- `TMO`, default 255: watchdog limit in cycles, range 1..255. The counter is 8 bits wide.

- `clk`  in  1  system clock; all state updates on its rising edge
- `rst`  in  1  synchronous reset, active-high
- `f_adr`  in  16  f-master address
- `f_stb`  in  1  f-master request; held until acked
- `f_wre`  in  1  f-master write enable
- `f_dto`  in  16  f-master write data
- `f_dti`  out  16  read data to f; valid only when `f_ack`=1
- `f_ack`  out  1  transaction complete to f
- `g_adr`, `g_stb`, `g_wre`, `g_dto`, `g_dti`, `g_ack`: same as the f ports, for the g master
- `m_adr`  out  16  slave address
- `m_stb`  out  1  slave request
- `m_wre`  out  1  slave write enable
- `m_dto`  out  16  slave write data
- `m_dti`  in  16  slave read data
- `m_ack`  in  1  slave acknowledge
- `gnt`  out  2  current owner, one-hot: bit0=f, bit1=g, 00 when idle
- `tmo`  out  1  sticky watchdog flag
- `tmo_clr`  in  1  clears `tmo`

## Operation
- **States:**
  - IDLE, BUSF, BUSG.
  - `gnt` decodes the state directly: 00 / 01 / 10.
  - `last` register holds the last-served master.
- **IDLE:**
  - Only `f_stb` set → BUSF.
  - Only `g_stb` set → BUSG.
  - Both set → the master that is not `last`.
  - Neither set → stay in IDLE.
- **BUSx datapath (combinational mux):**
  - `m_adr`, `m_wre`, `m_dto` follow owner x.
  - `m_stb` = `x_stb`.
  - `x_ack` = `m_ack`; the non-owner ack is 0.
- **IDLE datapath:** `m_stb`, `m_wre`, `m_adr`, `m_dto` all driven 0.
- **Read data:**
  - `f_dti` and `g_dti` are both driven with `m_dti`.
  - Exception: during a watchdog ack the owner's `dti` is 16'h0000.
- **Completion, when `m_ack` is seen in BUSx:**
  - `last` ← x.
  - If the other master's stb is set in that cycle → go directly to its BUS state (handoff, no idle cycle).
  - Otherwise → IDLE.
- **Abort:** owner drops stb without ack → IDLE next cycle. No ack is issued, and `last` is unchanged.
- **Watchdog:**
  - `cnt` is cleared on entry to any BUS state.
  - `cnt` increments on each BUS cycle without `m_ack`.
  - When `cnt`==`TMO` and `m_ack`=0, in that same cycle: `x_ack`=1, `x_dti`=0, `m_stb` forced 0.
  - On the next edge: `tmo` ← 1, then state and `last` update as for a normal completion.
- **`tmo` flag:**
  - `tmo_clr`=1 clears `tmo`.
  - If a timeout and `tmo_clr` coincide, set wins.
- **Ignored inputs:**
  - `m_ack` received while in IDLE is ignored.
  - Non-owner stb/adr/data are ignored until that master is granted.

## Timing
- **Reset values:** state=IDLE, `gnt`=00, `last`=g (so f wins the first tie), `cnt`=0, `tmo`=0, `f_ack`=`g_ack`=0, `m_stb`=0, `m_wre`=0, `m_adr`=0, `m_dto`=0.
- **Reset mid-transaction:** the transaction is dropped, no ack is issued, and outputs return to reset values the cycle after reset is sampled.
- **Grant latency:**
  - From IDLE: one cycle. stb sampled at edge N → `gnt`/`m_stb` valid after edge N.
  - Handoff: zero idle cycles. The second master drives the slave in the cycle after the first master's ack.
- **Ack path:** slave-to-master ack is combinational, zero added latency. A slave acking in its first strobed cycle gives a 2-cycle transaction measured from request in IDLE.
- **Watchdog:** fake ack occurs in the (`TMO`+1)-th cycle of ownership. A real `m_ack` in that same cycle takes precedence: normal ack, `tmo` not set.
- **Masters:** must drop stb in the cycle after their ack. A stb still high after the ack is treated as a new request.

## Test plan
- **Single read:**
  - Stimulus: `f_stb`=1, `f_adr`=0x1234, `f_wre`=0; slave acks 1 cycle later with `m_dti`=0xBEEF.
  - Required: `gnt`=01 after 1 cycle, `m_adr`=0x1234, `f_ack`=1 with `f_dti`=0xBEEF, `g_ack`=0, then `gnt`=00.
- **Simultaneous requests after reset:**
  - Stimulus: f and g request in the same cycle.
  - Required: f is served first, g is granted the cycle after f's ack (handoff), then IDLE. Repeat → f first again (`last`=g).
- **Fairness:**
  - Stimulus: f re-requests continuously while g requests.
  - Required: grants alternate f,g,f,g; no master is granted twice in a row while the other waits.
- **Watchdog:**
  - Stimulus: `TMO`=4, g write, slave never acks.
  - Required: `g_ack`=1 in the 5th owned cycle, `m_stb`=0 in that cycle, `tmo`=1 next cycle. `tmo_clr` → `tmo`=0.
- **Abort and reset:**
  - Abort: f drops stb mid-transaction → IDLE with no ack.
  - Reset: `rst` asserted during BUSG → all outputs reach reset values after one edge; a later g request is granted normally.
